// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and address helpers for the gray/LBP image host.
package lbp_pkg;

  localparam int unsigned IMG_W        = 128;
  localparam int unsigned IMG_H        = 128;
  localparam int unsigned LOG2_W       = 7;
  localparam int unsigned ADDR_W       = 14;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ROW_W        = ADDR_W - LOG2_W;
  localparam int unsigned NPIX         = IMG_W * IMG_H;
  localparam int unsigned INTERIOR_CNT = (IMG_W - 2) * (IMG_H - 2);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lbp_wr_t;

  // True for any pixel on the outer one-pixel frame of the image.
  function automatic logic is_border(input logic [ADDR_W-1:0] addr);
    logic [ROW_W-1:0]  row;
    logic [LOG2_W-1:0] col;
    row = addr[ADDR_W-1:LOG2_W];
    col = addr[LOG2_W-1:0];
    return (row == '0) || (row == ROW_W'(IMG_H - 1)) ||
           (col == '0) || (col == LOG2_W'(IMG_W - 1));
  endfunction

endpackage

// File: rtl/lbp_img_ram.sv
// Simple dual-port image RAM: synchronous write, async or registered read.
module lbp_img_ram #(
  parameter int unsigned AW      = 14,
  parameter int unsigned DW      = 8,
  parameter bit          RD_SYNC = 1'b0
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  generate
    if (RD_SYNC) begin : g_sync
      logic [DW-1:0] rdata_q;

      always_ff @(posedge clk) begin
        if (re_i) begin
          rdata_q <= mem_q[raddr_i];
        end
      end

      assign rdata_o = rdata_q;
    end else begin : g_async
      // Async port reads every cycle; the enable has no role here.
      logic unused_re;
      assign unused_re = re_i;
      assign rdata_o   = mem_q[raddr_i];
    end
  endgenerate

endmodule

// File: rtl/lbp_img_host.sv
// Image host for the LBP engine: loads a gray image, serves reads, collects
// results and exposes them through a read-out port once the engine finishes.
module lbp_img_host
  import lbp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              done,
  output logic [ADDR_W-1:0] wr_cnt,
  output logic              err,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic              err_q, err_d;
  logic              ld_ready_q, gray_ready_q, done_q;
  logic [DATA_W-1:0] gray_hold_q;
  logic              rd_valid_q, rd_zero_q;

  logic              ld_acc, gray_rd, rd_fire;
  logic              wr_hit, wr_legal, wr_bad;
  logic [DATA_W-1:0] gray_rdata, res_rdata;
  lbp_wr_t           res_wr;

  assign res_wr   = '{addr: lbp_addr, data: lbp_data};
  assign ld_acc   = ld_ready_q & ld_valid;
  assign gray_rd  = gray_req & (state_q != ST_LOAD);
  assign rd_fire  = rd_en & (state_q == ST_DONE);
  assign wr_hit   = lbp_valid & (state_q == ST_SERVE);
  assign wr_legal = wr_hit & ~is_border(res_wr.addr);
  assign wr_bad   = wr_hit & is_border(res_wr.addr);

  lbp_img_ram #(
    .AW      (ADDR_W),
    .DW      (DATA_W),
    .RD_SYNC (1'b0)
  ) u_gray_ram (
    .clk     (clk),
    .we_i    (ld_acc),
    .waddr_i (ptr_q),
    .wdata_i (ld_data),
    .re_i    (gray_rd),
    .raddr_i (gray_addr),
    .rdata_o (gray_rdata)
  );

  lbp_img_ram #(
    .AW      (ADDR_W),
    .DW      (DATA_W),
    .RD_SYNC (1'b1)
  ) u_res_ram (
    .clk     (clk),
    .we_i    (wr_legal),
    .waddr_i (res_wr.addr),
    .wdata_i (res_wr.data),
    .re_i    (rd_fire),
    .raddr_i (rd_addr),
    .rdata_o (res_rdata)
  );

  // Next-state, load pointer, result counter and sticky error.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_cnt_d = wr_cnt_q;
    err_d    = err_q;
    case (state_q)
      ST_LOAD: begin
        if (ld_acc) begin
          if (ptr_q == ADDR_W'(NPIX - 1)) begin
            state_d = ST_SERVE;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_SERVE: begin
        if (wr_legal && (wr_cnt_q != '1)) begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
        end
        if (wr_bad) begin
          err_d = 1'b1;
        end
        if (finish) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      ptr_q        <= '0;
      wr_cnt_q     <= '0;
      err_q        <= 1'b0;
      ld_ready_q   <= 1'b0;
      gray_ready_q <= 1'b0;
      done_q       <= 1'b0;
      gray_hold_q  <= '0;
      rd_valid_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      wr_cnt_q     <= wr_cnt_d;
      err_q        <= err_d;
      ld_ready_q   <= (state_d == ST_LOAD);
      gray_ready_q <= (state_d != ST_LOAD);
      done_q       <= (state_d == ST_DONE);
      rd_valid_q   <= rd_fire;
      if (gray_rd) begin
        gray_hold_q <= gray_rdata;
      end
      // Border read-outs return zero without relying on RAM contents.
      if (rd_fire) begin
        rd_zero_q <= is_border(rd_addr);
      end
    end
  end

  assign ld_ready   = ld_ready_q;
  assign gray_ready = gray_ready_q;
  assign gray_data  = gray_rd ? gray_rdata : gray_hold_q;
  assign done       = done_q;
  assign wr_cnt     = wr_cnt_q;
  assign err        = err_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_zero_q ? '0 : res_rdata;

endmodule

// File: tb/tb_lbp_img_host.sv
// Self-checking bench for lbp_img_host with a behavioural image/result model.
module tb_lbp_img_host;

  localparam int W        = 128;
  localparam int H        = 128;
  localparam int NP       = W * H;
  localparam int INTERIOR = (W - 2) * (H - 2);

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, ld_ready, gray_ready, gray_req;
  logic        lbp_valid, finish, done, err, rd_en, rd_valid;
  logic [7:0]  ld_data, gray_data, lbp_data, rd_data;
  logic [13:0] gray_addr, lbp_addr, wr_cnt, rd_addr;

  int errors = 0;
  int checks = 0;

  logic [7:0] gray_m [NP];
  logic [7:0] res_m  [NP];

  always #5 clk = ~clk;

  lbp_img_host dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .done       (done),
    .wr_cnt     (wr_cnt),
    .err        (err),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  function automatic bit on_border(input int a);
    int r;
    int c;
    r = a / W;
    c = a % W;
    return (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
  endfunction

  // Golden LBP: bit k set when the k-th neighbour (raster order) >= centre.
  function automatic logic [7:0] lbp_golden(input int r, input int c);
    logic [7:0] code;
    logic [7:0] ctr;
    int k;
    code = 8'h00;
    ctr  = gray_m[r * W + c];
    k    = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0)) begin
          if (gray_m[(r + dr) * W + (c + dc)] >= ctr) code[k] = 1'b1;
          k++;
        end
      end
    end
    return code;
  endfunction

  function automatic logic [7:0] rd_expect(input int a);
    return on_border(a) ? 8'h00 : res_m[a];
  endfunction

  task automatic idle_inputs();
    ld_valid  = 1'b0;
    ld_data   = 8'h00;
    gray_req  = 1'b0;
    gray_addr = '0;
    lbp_valid = 1'b0;
    lbp_addr  = '0;
    lbp_data  = 8'h00;
    finish    = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    checks++;
    if ({ld_ready, gray_ready, done, err, rd_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {ld_ready, gray_ready, done, err, rd_valid});
    end
    checks++;
    if (wr_cnt !== 14'd0) begin
      errors++;
      $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt);
    end
    checks++;
    if (gray_data !== 8'h00 || rd_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: gray_data=%h rd_data=%h want 00/00", gray_data, rd_data);
    end
    tick();
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ld_ready_rise: got %b want 1", ld_ready);
    end
  endtask

  // Streams a full image while driving noise on every port LOAD must ignore.
  task automatic test_load(input bit rand_valid, input bit rand_data);
    int idx;
    int cyc;
    bit acc;
    bit early;
    bit gd_bad;
    bit ign_bad;
    logic [7:0] pix;
    idx = 0; cyc = 0; early = 0; gd_bad = 0; ign_bad = 0;
    while (idx < NP && cyc < 60000) begin
      pix       = rand_data ? 8'($urandom) : 8'(idx);
      ld_valid  = rand_valid ? ($urandom_range(3) != 0) : 1'b1;
      ld_data   = ld_valid ? pix : 8'($urandom);
      gray_req  = 1'($urandom_range(1));
      gray_addr = 14'($urandom);
      lbp_valid = 1'($urandom_range(1));
      lbp_addr  = 14'($urandom);
      lbp_data  = 8'($urandom);
      finish    = ($urandom_range(7) == 0);
      rd_en     = 1'($urandom_range(1));
      rd_addr   = 14'($urandom);
      #2;
      if (gray_data !== 8'h00) gd_bad = 1;
      acc = ld_valid && ld_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        gray_m[idx] = pix;
        idx++;
      end
      if (idx < NP && gray_ready !== 1'b0) early = 1;
      if (rd_valid !== 1'b0 || wr_cnt !== 14'd0 || err !== 1'b0 || done !== 1'b0) ign_bad = 1;
      cyc++;
    end
    idle_inputs();
    checks++;
    if (idx != NP) begin
      errors++;
      $display("FAIL load_timeout: accepted %0d pixels want %0d", idx, NP);
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL load_early_gray_ready: got early=1 want 0");
    end
    checks++;
    if (gray_ready !== 1'b1 || ld_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_end: gray_ready=%b ld_ready=%b want 1/0", gray_ready, ld_ready);
    end
    checks++;
    if (gd_bad || ign_bad) begin
      errors++;
      $display("FAIL load_ignore: gray_data_bad=%0d ignored_ports_bad=%0d want 0/0", gd_bad, ign_bad);
    end
    tick();
    checks++;
    if (ld_ready !== 1'b0 || gray_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_hold: ld_ready=%b gray_ready=%b want 0/1", ld_ready, gray_ready);
    end
  endtask

  task automatic test_serve_read();
    int a;
    gray_req  = 1'b1;
    gray_addr = 14'd300;
    #2;
    checks++;
    if (gray_data !== 8'd44 || gray_m[300] !== 8'd44) begin
      errors++;
      $display("FAIL gray_300: got %0d want 44", gray_data);
    end
    tick();
    gray_addr = 14'd129;
    rd_en     = 1'b1;
    rd_addr   = 14'd129;
    #2;
    checks++;
    if (gray_data !== gray_m[129]) begin
      errors++;
      $display("FAIL gray_129: got %0d want %0d", gray_data, gray_m[129]);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_en_in_serve: rd_valid=%b want 0", rd_valid);
    end
    gray_req  = 1'b0;
    rd_en     = 1'b0;
    gray_addr = 14'd5;
    #2;
    checks++;
    if (gray_data !== 8'd129) begin
      errors++;
      $display("FAIL gray_hold_same: got %0d want 129", gray_data);
    end
    tick();
    gray_addr = 14'($urandom);
    #2;
    checks++;
    if (gray_data !== 8'd129) begin
      errors++;
      $display("FAIL gray_hold_later: got %0d want 129", gray_data);
    end
    for (int i = 0; i < 8; i++) begin
      a         = $urandom_range(NP - 1);
      gray_req  = 1'b1;
      gray_addr = 14'(a);
      #2;
      checks++;
      if (gray_data !== gray_m[a]) begin
        errors++;
        $display("FAIL gray_rand addr=%0d: got %h want %h", a, gray_data, gray_m[a]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_serve_write();
    int border_list [5];
    border_list = '{127, 5, 127 * W + 5, 3 * W, 16383};
    lbp_valid = 1'b1;
    lbp_addr  = 14'd129;
    lbp_data  = 8'hA5;
    gray_req  = 1'b1;
    gray_addr = 14'd130;
    #2;
    checks++;
    if (gray_data !== gray_m[130]) begin
      errors++;
      $display("FAIL gray_with_write: got %h want %h", gray_data, gray_m[130]);
    end
    tick();
    res_m[129] = 8'hA5;
    gray_req   = 1'b0;
    checks++;
    if (wr_cnt !== 14'd1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_legal: wr_cnt=%0d err=%b want 1/0", wr_cnt, err);
    end
    foreach (border_list[i]) begin
      lbp_addr = 14'(border_list[i]);
      lbp_data = 8'h11;
      tick();
      checks++;
      if (wr_cnt !== 14'd1 || err !== 1'b1) begin
        errors++;
        $display("FAIL write_border addr=%0d: wr_cnt=%0d err=%b want 1/1", border_list[i], wr_cnt, err);
      end
    end
    idle_inputs();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL serve_done: got %b want 0", done);
    end
  endtask

  task automatic test_done_readout();
    int list [5];
    int prev;
    list = '{127, 129, 0, 16383, 130};
    lbp_valid = 1'b1;
    lbp_addr  = 14'd130;
    lbp_data  = 8'h5A;
    finish    = 1'b1;
    tick();
    res_m[130] = 8'h5A;
    idle_inputs();
    checks++;
    if (done !== 1'b1 || gray_ready !== 1'b1 || wr_cnt !== 14'd2) begin
      errors++;
      $display("FAIL finish_write: done=%b gray_ready=%b wr_cnt=%0d want 1/1/2", done, gray_ready, wr_cnt);
    end
    lbp_valid = 1'b1;
    lbp_addr  = 14'd129;
    lbp_data  = 8'h00;
    tick();
    lbp_valid = 1'b0;
    checks++;
    if (wr_cnt !== 14'd2) begin
      errors++;
      $display("FAIL done_write_ignored: wr_cnt=%0d want 2", wr_cnt);
    end
    prev = 0;
    foreach (list[i]) begin
      rd_en   = 1'b1;
      rd_addr = 14'(list[i]);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== rd_expect(list[i])) begin
        errors++;
        $display("FAIL readout addr=%0d: valid=%b data=%h want 1/%h", list[i], rd_valid, rd_data, rd_expect(list[i]));
      end
      prev = list[i];
    end
    rd_en   = 1'b0;
    rd_addr = 14'd127;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== rd_expect(prev)) begin
      errors++;
      $display("FAIL readout_idle: valid=%b data=%h want 0/%h", rd_valid, rd_data, rd_expect(prev));
    end
  endtask

  task automatic test_mid_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    test_load(1'b0, 1'b0);
    lbp_valid = 1'b1;
    lbp_addr  = 14'd200;
    lbp_data  = 8'h3C;
    tick();
    lbp_addr  = 14'd0;
    tick();
    lbp_valid = 1'b0;
    checks++;
    if (wr_cnt !== 14'd1 || err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_state: wr_cnt=%0d err=%b want 1/1", wr_cnt, err);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({gray_ready, done, err, ld_ready, rd_valid} !== 5'b0 || wr_cnt !== 14'd0 || gray_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: flags=%b wr_cnt=%0d gray_data=%h want 00000/0/00",
               {gray_ready, done, err, ld_ready, rd_valid}, wr_cnt, gray_data);
    end
    tick();
    checks++;
    if (ld_ready !== 1'b1 || gray_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_load: ld_ready=%b gray_ready=%b want 1/0", ld_ready, gray_ready);
    end
  endtask

  task automatic test_full_run();
    int a;
    int n;
    int issued;
    test_load(1'b0, 1'b1);
    n = 0;
    issued = 0;
    for (int r = 1; r < H - 1; r++) begin
      for (int c = 1; c < W - 1; c++) begin
        lbp_valid = 1'b1;
        lbp_addr  = 14'(r * W + c);
        lbp_data  = lbp_golden(r, c);
        res_m[r * W + c] = lbp_data;
        issued++;
        gray_req  = ((n % 16) == 0);
        a         = $urandom_range(NP - 1);
        gray_addr = 14'(a);
        #2;
        if (gray_req) begin
          checks++;
          if (gray_data !== gray_m[a]) begin
            errors++;
            $display("FAIL run_gray addr=%0d: got %h want %h", a, gray_data, gray_m[a]);
          end
        end
        tick();
        n++;
      end
    end
    idle_inputs();
    checks++;
    if (wr_cnt !== 14'(INTERIOR) || issued != INTERIOR || err !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL run_pre_finish: wr_cnt=%0d err=%b done=%b want %0d/0/0", wr_cnt, err, done, INTERIOR);
    end
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checks++;
    if (done !== 1'b1 || wr_cnt !== 14'd15876 || err !== 1'b0) begin
      errors++;
      $display("FAIL run_done: done=%b wr_cnt=%0d err=%b want 1/15876/0", done, wr_cnt, err);
    end
    for (int i = 0; i < 1500; i++) begin
      case (i)
        0:       a = 129;
        1:       a = 0;
        2:       a = NP - 1;
        3:       a = (H - 2) * W + (W - 2);
        default: a = $urandom_range(NP - 1);
      endcase
      rd_en   = 1'b1;
      rd_addr = 14'(a);
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== rd_expect(a)) begin
        errors++;
        $display("FAIL sweep addr=%0d: valid=%b data=%h want 1/%h", a, rd_valid, rd_data, rd_expect(a));
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL sweep_end: rd_valid=%b want 0", rd_valid);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_load(1'b1, 1'b0);
    test_serve_read();
    test_serve_write();
    test_done_readout();
    test_mid_reset();
    test_full_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
